ram_dp: RTL and testbench

RAM_DP -- requirements
Module: ram_dp

---
 rtl/ram_dp.sv | 74 +++++++
 tb/tb_ram_dp.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ram_dp.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module      : ram_dp
// Description : Simple dual-port RAM with one write port and one read port
//               that share a single clock. The read port is registered, so
//               data appears one clock after the read edge. The storage is
//               built from flops because reset must clear every word at once.
//
// Ports
//   clock      in   rising-edge clock for all sequential logic
//   RESET_N    in   asynchronous active-low reset; clears storage and data_out
//   data_in    in   [DATA_W-1:0] write data
//   wren       in   write enable, active-high
//   rden       in   read enable, active-high
//   wraddress  in   [ADDR_W-1:0] write address
//   rdaddress  in   [ADDR_W-1:0] read address
//   data_out   out  [DATA_W-1:0] registered read data
//   mem        out  [DATA_W-1:0] x DEPTH live view of every storage word
//
// Revision    : 1.0 - initial release
//============================================================================
module ram_dp #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              RESET_N,
    input  logic [DATA_W-1:0] data_in,
    input  logic              wren,
    input  logic              rden,
    input  logic [ADDR_W-1:0] wraddress,
    input  logic [ADDR_W-1:0] rdaddress,
    output logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] mem [DEPTH]
);

    logic [DATA_W-1:0] r_store [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // One register per word so the asynchronous reset can clear the whole
    // array in the same instant without a clocked sweep.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            logic w_hit;
            assign w_hit = wren && (wraddress == ADDR_W'(gi));

            always_ff @(posedge clock or negedge RESET_N) begin
                if (!RESET_N) begin
                    r_store[gi] <= '0;
                end else if (w_hit) begin
                    r_store[gi] <= data_in;
                end
            end

            assign mem[gi] = r_store[gi];
        end
    endgenerate

    // The read samples the array before the same edge's write lands, which
    // gives old-data behaviour on a same-address collision.
    always_ff @(posedge clock or negedge RESET_N) begin
        if (!RESET_N) begin
            r_rd_data <= '0;
        end else if (rden) begin
            r_rd_data <= r_store[rdaddress];
        end
    end

    assign data_out = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_ram_dp.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module      : tb_ram_dp
// Description : Self-checking bench for ram_dp. An array-based model of the
//               RAM is checked against data_out and every mem word on each
//               falling clock edge; directed sequences add literal checks.
// Revision    : 1.0 - initial release
//============================================================================
module tb_ram_dp;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic              clock;
    logic              RESET_N;
    logic [DATA_W-1:0] data_in;
    logic              wren;
    logic              rden;
    logic [ADDR_W-1:0] wraddress;
    logic [ADDR_W-1:0] rdaddress;
    logic [DATA_W-1:0] data_out;
    logic [DATA_W-1:0] mem [DEPTH];

    ram_dp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clock     (clock),
        .RESET_N   (RESET_N),
        .data_in   (data_in),
        .wren      (wren),
        .rden      (rden),
        .wraddress (wraddress),
        .rdaddress (rdaddress),
        .data_out  (data_out),
        .mem       (mem)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model state
    logic [DATA_W-1:0] exp_mem [DEPTH];
    logic [DATA_W-1:0] exp_dout;
    logic              chk_en;

    int n_cmp;
    int n_bad;

    task automatic check8(input string name, input logic [DATA_W-1:0] act,
                          input logic [DATA_W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%02h, expected 0x%02h", name, $time, act, req);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
        exp_dout = '0;
    endtask

    task automatic check_all_zero(input string name);
        check8({name, ".data_out"}, data_out, 8'h00);
        for (int i = 0; i < DEPTH; i++) check8({name, ".mem"}, mem[i], 8'h00);
    endtask

    // Drive one access, wait for the edge, then advance the model.
    task automatic step(input logic w, input logic [ADDR_W-1:0] wa,
                        input logic [DATA_W-1:0] d, input logic r,
                        input logic [ADDR_W-1:0] ra);
        wren = w; wraddress = wa; data_in = d; rden = r; rdaddress = ra;
        @(posedge clock);
        #1;
        if (RESET_N) begin
            if (r) exp_dout = exp_mem[ra];
            if (w) exp_mem[wa] = d;
        end
        wren = 1'b0; rden = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0);
    endtask

    // Continuous compare against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            check8("model.data_out", data_out, exp_dout);
            for (int i = 0; i < DEPTH; i++) check8("model.mem", mem[i], exp_mem[i]);
        end
    end

    initial begin
        n_cmp = 0; n_bad = 0; chk_en = 1'b0;
        RESET_N = 1'b0;
        wren = 1'b0; rden = 1'b0; data_in = '0; wraddress = '0; rdaddress = '0;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("reset_state");
        RESET_N = 1'b1;
        chk_en = 1'b1;

        // Reset then read: word 7 written first so a missed clear would show.
        step(1'b1, 5'd7, 8'hC3, 1'b0, '0);
        #2; RESET_N = 1'b0; model_clear();
        #2; RESET_N = 1'b1;
        step(1'b0, '0, '0, 1'b1, 5'd7);
        check8("reset_read.data_out", data_out, 8'h00);
        for (int i = 0; i < DEPTH; i++) check8("reset_read.mem", mem[i], 8'h00);

        // Write then read
        step(1'b1, 5'd3, 8'hA5, 1'b0, '0);
        check8("wr_rd.mem3", mem[3], 8'hA5);
        step(1'b0, '0, '0, 1'b1, 5'd3);
        check8("wr_rd.data_out", data_out, 8'hA5);

        // Same-address collision returns old data
        step(1'b1, 5'd5, 8'h11, 1'b0, '0);
        step(1'b1, 5'd5, 8'h22, 1'b1, 5'd5);
        check8("collision.data_out", data_out, 8'h11);
        check8("collision.mem5", mem[5], 8'h22);

        // Different addresses on the same edge
        step(1'b1, 5'd10, 8'h77, 1'b1, 5'd3);
        check8("diff_addr.data_out", data_out, 8'hA5);
        check8("diff_addr.mem10", mem[10], 8'h77);

        // Fill and read back
        for (int a = 0; a < DEPTH; a++) step(1'b1, ADDR_W'(a), DATA_W'(a), 1'b0, '0);
        for (int a = 0; a < DEPTH; a++) begin
            step(1'b0, '0, '0, 1'b1, ADDR_W'(a));
            check8("fill.data_out", data_out, DATA_W'(a));
        end

        // Hold with both enables low
        step(1'b1, 5'd12, 8'h5A, 1'b0, '0);
        step(1'b0, '0, '0, 1'b1, 5'd12);
        check8("hold.first", data_out, 8'h5A);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 5'd12, 8'hFF, 1'b0, 5'd0);
            check8("hold.data_out", data_out, 8'h5A);
            check8("hold.mem12", mem[12], 8'h5A);
            check8("hold.mem0", mem[0], 8'h00);
        end

        // Reset mid-stream: clears immediately, before the next edge
        step(1'b1, 5'd20, 8'hE7, 1'b1, 5'd12);
        #2; RESET_N = 1'b0; model_clear();
        #1;
        check_all_zero("async_reset");
        // Accesses while in reset are ignored
        step(1'b1, 5'd9, 8'h99, 1'b1, 5'd20);
        check_all_zero("in_reset");
        #1; RESET_N = 1'b1;
        // First edge after release is accepted
        step(1'b1, 5'd9, 8'h3C, 1'b0, '0);
        check8("post_reset.mem9", mem[9], 8'h3C);
        step(1'b0, '0, '0, 1'b1, 5'd9);
        check8("post_reset.data_out", data_out, 8'h3C);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
